// File: rtl/mii_tx_arb_pkg.sv
// Shared definitions for the MII transmit arbiter: state encodings, default IPG length
// and the round-robin winner helper.
package mii_tx_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_IPG   = 2'd3;

    // 24 nibbles = 96 bit times of inter-packet gap
    localparam int unsigned MII_IPG_NIBBLES_DEF = 24;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT,
        SEND  = ST_SEND,
        IPG   = ST_IPG
    } state_t;

    // Winner index: the pointer breaks a tie, otherwise the lone requester wins.
    function automatic logic pick(input logic [1:0] req, input logic ptr);
        return (req == 2'b11) ? ptr : req[1];
    endfunction

endpackage

// File: rtl/mii_tx_arb.sv
// Two-requester round-robin arbiter driving one MII transmit port with enforced IPG.
// Define MII_TX_ARB_DEFER_EN for the half-duplex build that defers to carrier sense.
module mii_tx_arb
    import mii_tx_arb_pkg::*;
#(
    parameter int unsigned IPG_NIBBLES = MII_IPG_NIBBLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       link_status,
    input  logic       crs,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic [1:0] en,
    input  logic [1:0] er,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    output logic       tx_en,
    output logic       tx_er,
    output logic [3:0] txd
);

    localparam logic [7:0] IPG_LOAD = 8'(IPG_NIBBLES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_ptr;
    logic       r_g;
    logic [1:0] r_gnt;
    logic       r_tx_en;
    logic       r_tx_er;
    logic [3:0] r_txd;

    logic       w_crs;
    logic       w_win;
    logic       w_en;
    logic       w_er;
    logic [3:0] w_d;

`ifdef MII_TX_ARB_DEFER_EN
    logic r_crs_s1;
    logic r_crs_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crs_s1 <= 1'b0;
            r_crs_s2 <= 1'b0;
        end else begin
            r_crs_s1 <= crs;
            r_crs_s2 <= r_crs_s1;
        end
    end

    assign w_crs = r_crs_s2;
`else
    logic w_unused_crs;
    assign w_unused_crs = crs;
    assign w_crs        = 1'b0;
`endif

    assign w_win = pick(req, r_ptr);
    assign w_en  = en[r_g];
    assign w_er  = er[r_g];
    assign w_d   = r_g ? d1 : d0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IPG;
            r_cnt   <= IPG_LOAD;
            r_ptr   <= 1'b0;
            r_g     <= 1'b0;
            r_gnt   <= 2'b00;
            r_tx_en <= 1'b0;
            r_tx_er <= 1'b0;
            r_txd   <= 4'h0;
        end else if (!link_status) begin
            // Link loss acts immediately, independent of the nibble strobe
            r_state <= IPG;
            r_cnt   <= IPG_LOAD;
            r_gnt   <= 2'b00;
            r_tx_en <= 1'b0;
            r_tx_er <= 1'b0;
            r_txd   <= 4'h0;
        end else if (ce) begin
            case (r_state)
                IDLE: begin
                    if (w_crs) begin
                        r_state <= IPG;
                        r_cnt   <= IPG_LOAD;
                    end else if (|req) begin
                        r_g     <= w_win;
                        r_gnt   <= w_win ? 2'b10 : 2'b01;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    // Outputs only leave zero on the nibble that starts SEND
                    if (w_en) begin
                        r_state <= SEND;
                        r_tx_en <= 1'b1;
                        r_tx_er <= w_er;
                        r_txd   <= w_d;
                    end else if (!req[r_g]) begin
                        r_state <= IDLE;
                        r_gnt   <= 2'b00;
                    end
                end
                SEND: begin
                    if (w_en) begin
                        r_tx_er <= w_er;
                        r_txd   <= w_d;
                    end else begin
                        r_state <= IPG;
                        r_cnt   <= IPG_LOAD;
                        r_gnt   <= 2'b00;
                        r_tx_en <= 1'b0;
                        r_tx_er <= 1'b0;
                        r_txd   <= 4'h0;
                        r_ptr   <= ~r_g;
                    end
                end
                IPG: begin
                    if (w_crs)
                        r_cnt <= IPG_LOAD;
                    else if (r_cnt == 8'd0)
                        r_state <= IDLE;
                    else
                        r_cnt <= r_cnt - 8'd1;
                end
                default: r_state <= IPG;
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign tx_en = r_tx_en;
    assign tx_er = r_tx_er;
    assign txd   = r_txd;

endmodule
